// File: rtl/ysyx_24100005_imem_pkg.sv
// Shared definitions for the instruction-memory responder: FSM encoding,
// default base address (also the core's reset PC) and latency counter width.
package ysyx_24100005_imem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [31:0] DEFAULT_BASE = 32'h8000_0000;
    localparam int unsigned CNT_W        = 4;

endpackage

// File: rtl/ysyx_24100005_imem_array.sv
// DEPTH x 32 synchronous instruction store: one write port, one registered
// read port with read-before-write behaviour on same-word collisions. No reset.
module ysyx_24100005_imem_array #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_idx,
    input  logic [31:0]   wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_idx,
    output logic [31:0]   rd_data
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_idx];
        end
    end

endmodule

// File: rtl/ysyx_24100005_imem_resp.sv
// Instruction-memory responder: valid/ready fetch request in, instruction word
// out after LATENCY cycles, with misaligned/out-of-range fetches flagged.
module ysyx_24100005_imem_resp
    import ysyx_24100005_imem_pkg::*;
#(
    parameter logic [31:0] BASE    = DEFAULT_BASE,
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_err,
    input  logic        wr_en,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data
);

    localparam int unsigned      AW       = $clog2(DEPTH);
    localparam logic [31:0]      SPAN     = 32'(DEPTH) << 2;
    localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY >= 2) ? CNT_W'(LATENCY - 2) : '0;

    function automatic logic in_map(input logic [31:0] a);
        return (a >= BASE) && ((a - BASE) < SPAN) && (a[1:0] == 2'b00);
    endfunction

    function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
        return AW'((a - BASE) >> 2);
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      addr_q, addr_d;
    logic             err_q, err_d;
    logic             resp_err_q;
    logic             data_ok_q;
    logic             enter_resp;
    logic             cur_err;
    logic [AW-1:0]    rd_idx;
    logic [31:0]      rd_data;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        err_d      = err_q;
        req_ready  = 1'b0;
        enter_resp = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_d = req_addr;
                    err_d  = !in_map(req_addr);
                    if (LATENCY == 1) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        cnt_d   = CNT_LOAD;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // With LATENCY == 1 the read is captured on the accept edge itself,
    // so decode straight from the request port rather than the latched copy.
    always_comb begin
        cur_err = err_q;
        rd_idx  = word_idx(addr_q);
        if (state_q == IDLE) begin
            cur_err = !in_map(req_addr);
            rd_idx  = word_idx(req_addr);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            err_q      <= 1'b0;
            resp_err_q <= 1'b0;
            data_ok_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
            if (enter_resp) begin
                resp_err_q <= cur_err;
                data_ok_q  <= !cur_err;
            end
        end
    end

    ysyx_24100005_imem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .wr_en   (wr_en && in_map(wr_addr)),
        .wr_idx  (word_idx(wr_addr)),
        .wr_data (wr_data),
        .rd_en   (enter_resp && !cur_err),
        .rd_idx  (rd_idx),
        .rd_data (rd_data)
    );

    // The store has no reset, so the output is masked until a good read lands.
    assign resp_data  = data_ok_q ? rd_data : '0;
    assign resp_err   = resp_err_q;
    assign resp_valid = (state_q == RESP);

endmodule

// File: tb/tb_ysyx_24100005_imem_resp.sv
// Directed bench for the instruction-memory responder; three instances cover
// LATENCY = 1, 3 and 4 against hand-computed expectations.
module tb_ysyx_24100005_imem_resp;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  req_valid, req_ready, resp_valid, resp_ready, resp_err, wr_en;
    logic [31:0] req_addr [3];
    logic [31:0] resp_data [3];
    logic [31:0] wr_addr [3];
    logic [31:0] wr_data [3];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ysyx_24100005_imem_resp #(.LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_data(resp_data[0]), .resp_err(resp_err[0]),
        .wr_en(wr_en[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0])
    );

    ysyx_24100005_imem_resp #(.LATENCY(3)) u_l3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_data(resp_data[1]), .resp_err(resp_err[1]),
        .wr_en(wr_en[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1])
    );

    ysyx_24100005_imem_resp #(.LATENCY(4)) u_l4 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_addr(req_addr[2]),
        .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]),
        .resp_data(resp_data[2]), .resp_err(resp_err[2]),
        .wr_en(wr_en[2]), .wr_addr(wr_addr[2]), .wr_data(wr_data[2])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int i, input logic [31:0] a, input logic [31:0] d);
        wr_en[i]   = 1'b1;
        wr_addr[i] = a;
        wr_data[i] = d;
        tick();
        wr_en[i] = 1'b0;
    endtask

    // Issues one fetch and checks latency, busy req_ready, data, error and the
    // return to IDLE. With bp set, the response is held off for 5 cycles while
    // stray requests are pulsed and must be ignored.
    task automatic do_fetch(input int i, input logic [31:0] a, input int exp_lat,
                            input logic [31:0] exp_data, input logic exp_err,
                            input string tag, input bit bp);
        int lat;
        resp_ready[i] = !bp;
        req_valid[i]  = 1'b1;
        req_addr[i]   = a;
        chk({tag, "_ready_at_accept"}, 32'(req_ready[i]), 32'd1);
        tick();
        req_valid[i] = 1'b0;
        wr_en[i]     = 1'b0;
        req_addr[i]  = 32'h8000_000C;
        lat = 1;
        while (!resp_valid[i] && lat < 40) begin
            chk({tag, "_busy"}, 32'(req_ready[i]), 32'd0);
            tick();
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_data"}, resp_data[i], exp_data);
        chk({tag, "_err"}, 32'(resp_err[i]), 32'(exp_err));
        chk({tag, "_ready_in_resp"}, 32'(req_ready[i]), 32'd0);
        if (bp) begin
            for (int k = 0; k < 5; k++) begin
                req_valid[i] = k[0];
                req_addr[i]  = 32'h8000_0004;
                tick();
                chk({tag, "_hold_valid"}, 32'(resp_valid[i]), 32'd1);
                chk({tag, "_hold_data"}, resp_data[i], exp_data);
                chk({tag, "_hold_err"}, 32'(resp_err[i]), 32'(exp_err));
                chk({tag, "_hold_ready"}, 32'(req_ready[i]), 32'd0);
            end
            req_valid[i]  = 1'b0;
            resp_ready[i] = 1'b1;
        end
        tick();
        chk({tag, "_idle_valid"}, 32'(resp_valid[i]), 32'd0);
        chk({tag, "_idle_ready"}, 32'(req_ready[i]), 32'd1);
        chk({tag, "_keep_data"}, resp_data[i], exp_data);
        chk({tag, "_keep_err"}, 32'(resp_err[i]), 32'(exp_err));
        if (bp) begin
            tick();
            chk({tag, "_no_extra"}, 32'(resp_valid[i]), 32'd0);
        end
    endtask

    initial begin
        req_valid  = '0;
        resp_ready = '0;
        wr_en      = '0;
        for (int i = 0; i < 3; i++) begin
            req_addr[i] = '0;
            wr_addr[i]  = '0;
            wr_data[i]  = '0;
        end
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("rst_resp_valid", 32'(resp_valid[i]), 32'd0);
            chk("rst_resp_data", resp_data[i], 32'd0);
            chk("rst_resp_err", 32'(resp_err[i]), 32'd0);
            chk("rst_req_ready", 32'(req_ready[i]), 32'd1);
        end
        rst = 1'b1;
        tick();

        // LATENCY = 1 basic fetch
        wr(0, 32'h8000_0000, 32'h0010_0093);
        do_fetch(0, 32'h8000_0000, 1, 32'h0010_0093, 1'b0, "l1_basic", 1'b0);

        // LATENCY = 3 fetch and backpressure
        wr(1, 32'h8000_0004, 32'h0000_0073);
        do_fetch(1, 32'h8000_0004, 3, 32'h0000_0073, 1'b0, "l3_basic", 1'b0);
        wr(1, 32'h8000_0000, 32'h1234_5678);
        do_fetch(1, 32'h8000_0000, 3, 32'h1234_5678, 1'b0, "l3_bp", 1'b1);

        // Error fetches and the last in-range word
        do_fetch(0, 32'h8000_0002, 1, 32'h0, 1'b1, "err_misalign", 1'b0);
        do_fetch(0, 32'h7FFF_FFFC, 1, 32'h0, 1'b1, "err_below", 1'b0);
        do_fetch(0, 32'h8000_1000, 1, 32'h0, 1'b1, "err_past_end", 1'b0);
        wr(0, 32'h8000_0FFC, 32'h5A5A_A5A5);
        do_fetch(0, 32'h8000_0FFC, 1, 32'h5A5A_A5A5, 1'b0, "last_word", 1'b0);

        // Read-before-write collision on the capture edge, then ignored write
        wr(0, 32'h8000_0008, 32'hAAAA_0001);
        wr_en[0]   = 1'b1;
        wr_addr[0] = 32'h8000_0008;
        wr_data[0] = 32'hBBBB_0002;
        do_fetch(0, 32'h8000_0008, 1, 32'hAAAA_0001, 1'b0, "coll_old", 1'b0);
        do_fetch(0, 32'h8000_0008, 1, 32'hBBBB_0002, 1'b0, "coll_new", 1'b0);
        wr(0, 32'h9000_0000, 32'hFFFF_FFFF);
        do_fetch(0, 32'h8000_0000, 1, 32'h0010_0093, 1'b0, "oor_wr_w0", 1'b0);
        do_fetch(0, 32'h8000_0008, 1, 32'hBBBB_0002, 1'b0, "oor_wr_w2", 1'b0);

        // Reset during WAIT with LATENCY = 4
        wr(2, 32'h8000_0010, 32'hCAFE_F00D);
        resp_ready[2] = 1'b1;
        req_valid[2]  = 1'b1;
        req_addr[2]   = 32'h8000_0010;
        tick();
        req_valid[2] = 1'b0;
        chk("l4_in_wait", 32'(req_ready[2]), 32'd0);
        rst = 1'b0;
        #2;
        chk("l4_rst_valid", 32'(resp_valid[2]), 32'd0);
        chk("l4_rst_ready", 32'(req_ready[2]), 32'd1);
        tick();
        rst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk("l4_no_stale", 32'(resp_valid[2]), 32'd0);
            tick();
        end
        chk("l4_ready_after", 32'(req_ready[2]), 32'd1);
        do_fetch(2, 32'h8000_0010, 4, 32'hCAFE_F00D, 1'b0, "l4_preserved", 1'b0);
        do_fetch(0, 32'h8000_0000, 1, 32'h0010_0093, 1'b0, "l1_preserved", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
